// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the multiply/divide unit.
//   - req_op encodings (OP_MULT .. OP_MTLO; codes 6/7 are reserved)
//   - control FSM state enum (ST_IDLE, ST_MUL, ST_DIV)
//   - clog2(): width helper for iteration counters
package mdu_pkg;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } state_e;

  // Smallest r with 2**r >= value.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/mdu_div_iter.sv
// mdu_div_iter: restoring radix-2 unsigned divider, one quotient bit per cycle.
//   clk, rst_n   : clock, asynchronous active-low reset
//   start_i      : load dividend_i/divisor_i and begin (ignored while cancel_i)
//   cancel_i     : abandon the division in progress
//   dividend_i   : unsigned dividend
//   divisor_i    : unsigned divisor
//   done_o       : high during the last iteration cycle; quot_o/rem_o valid then
//   quot_o/rem_o : result of the last iteration (combinational, valid with done_o)
// XLEN iterations follow the loading edge; done_o is asserted in the cycle
// before the edge that would complete the last iteration, so the caller can
// capture the result on that same edge.
module mdu_div_iter
  import mdu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = clog2(XLEN + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic            cancel_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic            done_o,
  output logic [XLEN-1:0] quot_o,
  output logic [XLEN-1:0] rem_o
);

  logic [XLEN-1:0]  rem_q, quo_q, dvs_q;
  logic [CNT_W-1:0] cnt_q;
  logic             active_q;

  logic [XLEN:0]    shifted, trial;
  logic             qbit;
  logic [XLEN-1:0]  rem_n, quo_n;

  // Partial remainder shifted left with the next dividend bit; the top bit of
  // the XLEN+1 bit difference is the borrow of the trial subtraction.
  always_comb begin
    shifted = {rem_q, quo_q[XLEN-1]};
    trial   = shifted - {1'b0, dvs_q};
    qbit    = ~trial[XLEN];
    rem_n   = qbit ? trial[XLEN-1:0] : shifted[XLEN-1:0];
    quo_n   = {quo_q[XLEN-2:0], qbit};
  end

  assign done_o = active_q && (cnt_q == CNT_W'(XLEN - 1));
  assign quot_o = quo_n;
  assign rem_o  = rem_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else if (cancel_i) begin
      active_q <= 1'b0;
    end else if (start_i) begin
      rem_q    <= '0;
      quo_q    <= dividend_i;
      dvs_q    <= divisor_i;
      cnt_q    <= '0;
      active_q <= 1'b1;
    end else if (active_q) begin
      rem_q <= rem_n;
      quo_q <= quo_n;
      cnt_q <= cnt_q + CNT_W'(1);
      if (done_o) active_q <= 1'b0;
    end
  end

endmodule

// File: rtl/mdu_hilo_unit.sv
// mdu_hilo_unit: multiply/divide unit with architectural HI/LO registers.
//   clk, rst_n          : clock, asynchronous active-low reset
//   req_valid/req_ready : request handshake. A request transfers on a rising
//                         edge where req_valid && req_ready && !flush; the
//                         requester holds req_op/src0/src1 stable until then.
//   req_op              : 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 no-op
//   req_src0/req_src1   : operands (src0 is the data for MTHI/MTLO)
//   flush               : cancels the in-flight op, or blocks acceptance in idle
//   busy                : multiply or divide in flight
//   rd_sel/rd_data      : combinational read of HI (1) or LO (0)
//   rd_valid            : HI/LO hold final values (no write pending)
//   dbg_state           : current control FSM state (mdu_pkg::state_e encoding)
// Optional build macro MDU_EARLY_DIV_EN: a divide whose divisor is zero or
// larger in magnitude than the dividend completes two cycles after accept.
module mdu_hilo_unit
  import mdu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int MUL_LAT = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_op,
  input  logic [XLEN-1:0] req_src0,
  input  logic [XLEN-1:0] req_src1,
  input  logic            flush,
  output logic            busy,
  input  logic            rd_sel,
  output logic [XLEN-1:0] rd_data,
  output logic            rd_valid,
  output logic [1:0]      dbg_state
);

  localparam int CNT_W = clog2(XLEN + 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [XLEN-1:0]   a_q, a_d, b_q, b_d;
  logic              sgn_q, sgn_d;
  logic [2*XLEN-1:0] mul_pipe_q [MUL_LAT];

  logic              accept, mul_load, div_start, div_done;
  logic [2*XLEN-1:0] mul_a_ext, mul_b_ext, mul_prod;
  logic [XLEN-1:0]   mag_a, mag_b, div_quot, div_rem, res_q, res_r;

  assign accept    = req_valid && (state_q == ST_IDLE) && !flush;
  assign mul_load  = accept && ((req_op == OP_MULT) || (req_op == OP_MULTU));
  assign req_ready = (state_q == ST_IDLE);
  assign rd_valid  = (state_q == ST_IDLE);
  assign busy      = !rd_valid;
  assign rd_data   = rd_sel ? hi_q : lo_q;
  assign dbg_state = state_q;

  // Extending to 2*XLEN before a truncating multiply yields the correct
  // signed or unsigned product.
  always_comb begin
    mul_a_ext = {{XLEN{(req_op == OP_MULT) && req_src0[XLEN-1]}}, req_src0};
    mul_b_ext = {{XLEN{(req_op == OP_MULT) && req_src1[XLEN-1]}}, req_src1};
    mul_prod  = mul_a_ext * mul_b_ext;
  end

  // Operand magnitudes for the unsigned core. -MIN wraps to MIN, which is the
  // correct unsigned magnitude, so MIN / -1 naturally yields LO=MIN, HI=0.
  always_comb begin
    mag_a = (sgn_q && a_q[XLEN-1]) ? -a_q : a_q;
    mag_b = (sgn_q && b_q[XLEN-1]) ? -b_q : b_q;
    res_q = (sgn_q && (a_q[XLEN-1] ^ b_q[XLEN-1])) ? -div_quot : div_quot;
    res_r = (sgn_q && a_q[XLEN-1]) ? -div_rem : div_rem;
  end

`ifdef MDU_EARLY_DIV_EN
  logic early_q, early_d;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    a_d       = a_q;
    b_d       = b_q;
    sgn_d     = sgn_q;
    div_start = 1'b0;
`ifdef MDU_EARLY_DIV_EN
    early_d   = early_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          case (req_op)
            OP_MULT, OP_MULTU: begin
              state_d = ST_MUL;
              cnt_d   = '0;
            end
            OP_DIV, OP_DIVU: begin
              state_d = ST_DIV;
              cnt_d   = '0;
              a_d     = req_src0;
              b_d     = req_src1;
              sgn_d   = (req_op == OP_DIV);
`ifdef MDU_EARLY_DIV_EN
              early_d = 1'b0;
`endif
            end
            OP_MTHI: hi_d = req_src0;
            OP_MTLO: lo_d = req_src0;
            default: ;
          endcase
        end
      end
      ST_MUL: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_W'(MUL_LAT - 1)) begin
          {hi_d, lo_d} = mul_pipe_q[MUL_LAT-1];
          state_d      = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DIV: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else if (cnt_q == '0) begin
          // First cycle: magnitudes are formed and handed to the core.
          cnt_d = CNT_W'(1);
`ifdef MDU_EARLY_DIV_EN
          if ((b_q == '0) || (mag_b > mag_a)) early_d = 1'b1;
          else div_start = 1'b1;
`else
          div_start = 1'b1;
`endif
`ifdef MDU_EARLY_DIV_EN
        end else if (early_q) begin
          // Quotient is 0 (or all-ones for /0); remainder is the dividend.
          lo_d    = (b_q == '0) ? '1 : '0;
          hi_d    = a_q;
          state_d = ST_IDLE;
`endif
        end else if (div_done) begin
          if (b_q == '0) begin
            lo_d = '1;
            hi_d = a_q;
          end else begin
            lo_d = res_q;
            hi_d = res_r;
          end
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
`ifdef MDU_EARLY_DIV_EN
      early_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
`ifdef MDU_EARLY_DIV_EN
      early_q <= early_d;
`endif
    end
  end

  // Product register chain: stage 0 captures on the accepting edge, the last
  // stage is written to HI/LO MUL_LAT edges after accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < MUL_LAT; k++) mul_pipe_q[k] <= '0;
    end else begin
      if (mul_load) mul_pipe_q[0] <= mul_prod;
      for (int k = 1; k < MUL_LAT; k++) mul_pipe_q[k] <= mul_pipe_q[k-1];
    end
  end

  mdu_div_iter #(
    .XLEN  (XLEN),
    .CNT_W (CNT_W)
  ) u_div (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (div_start),
    .cancel_i   (flush),
    .dividend_i (mag_a),
    .divisor_i  (mag_b),
    .done_o     (div_done),
    .quot_o     (div_quot),
    .rem_o      (div_rem)
  );

endmodule

// File: tb/tb_mdu_hilo_unit.sv
// Bench for mdu_hilo_unit (XLEN=32, MUL_LAT=2). Inputs change on the falling
// edge, outputs are sampled on the falling edge (or a few ns after it).
module tb_mdu_hilo_unit;

  localparam int XLEN    = 32;
  localparam int MUL_LAT = 2;
  localparam int DIV_LAT = XLEN + 1;
`ifdef MDU_EARLY_DIV_EN
  localparam int EARLY_LAT = 2;
`else
  localparam int EARLY_LAT = DIV_LAT;
`endif

  logic            clk, rst_n;
  logic            req_valid, req_ready, flush, busy, rd_sel, rd_valid;
  logic [2:0]      req_op;
  logic [XLEN-1:0] req_src0, req_src1, rd_data;
  logic [1:0]      dbg_state;

  int n_cmp = 0;
  int n_err = 0;
  logic [XLEN-1:0] exp_q[$];
  logic [XLEN-1:0] mhi, mlo;

  mdu_hilo_unit #(.XLEN(XLEN), .MUL_LAT(MUL_LAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_src0  (req_src0),
    .req_src1  (req_src1),
    .flush     (flush),
    .busy      (busy),
    .rd_sel    (rd_sel),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic read_reg(input logic sel, output logic [XLEN-1:0] v);
    rd_sel = sel;
    #1;
    v = rd_data;
  endtask

  // Reference model: architectural result of one op from plain arithmetic.
  task automatic ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] hi_in, input logic [31:0] lo_in,
                           output logic [31:0] hi_o, output logic [31:0] lo_o, output int lat);
    longint sa, sb, ua, ub, q, r, ma, mb;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    hi_o = hi_in;
    lo_o = lo_in;
    lat  = 0;
    case (op)
      3'd0: begin p = 64'(sa * sb); hi_o = p[63:32]; lo_o = p[31:0]; lat = MUL_LAT; end
      3'd1: begin p = 64'(ua * ub); hi_o = p[63:32]; lo_o = p[31:0]; lat = MUL_LAT; end
      3'd2, 3'd3: begin
        if (op == 3'd2) begin
          ma = (sa < 0) ? -sa : sa;
          mb = (sb < 0) ? -sb : sb;
        end else begin
          ma = ua;
          mb = ub;
        end
        if (b == 0) begin
          lo_o = 32'hFFFF_FFFF;
          hi_o = a;
        end else begin
          q = (op == 3'd2) ? sa / sb : ua / ub;
          r = (op == 3'd2) ? sa % sb : ua % ub;
          lo_o = q[31:0];
          hi_o = r[31:0];
        end
        lat = (b == 0 || mb > ma) ? EARLY_LAT : DIV_LAT;
      end
      3'd4: hi_o = a;
      3'd5: lo_o = a;
      default: ;
    endcase
  endtask

  // Driver: present one request, wait for completion, check latency and HI/LO.
  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input int exp_lat);
    int cyc;
    logic [XLEN-1:0] v;
    cyc = 0;
    while (!req_ready && cyc < 100) begin @(negedge clk); cyc++; end
    req_valid = 1'b1;
    req_op    = op;
    req_src0  = a;
    req_src1  = b;
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 0;
    while (busy && cyc < 100) begin @(negedge clk); cyc++; end
    check({name, " busy_cycles"}, 32'(cyc), 32'(exp_lat));
    exp_q.push_back(exp_hi);
    exp_q.push_back(exp_lo);
    read_reg(1'b1, v);
    check({name, " hi"}, v, exp_q.pop_front());
    read_reg(1'b0, v);
    check({name, " lo"}, v, exp_q.pop_front());
  endtask

  typedef struct {
    string      name;
    logic [2:0] op;
    logic [31:0] a, b, hi, lo;
    int         lat;
  } vec_t;

  vec_t vecs[12];

  initial begin
    logic [XLEN-1:0] v, ra, rb, ehi, elo;
    int elat;

    vecs[0]  = '{"mult_neg1x2",   3'd0, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2};
    vecs[1]  = '{"multu_ffx2",    3'd1, 32'hFFFF_FFFF, 32'h2, 32'h0000_0001, 32'hFFFF_FFFE, 2};
    vecs[2]  = '{"div_m7_2",      3'd2, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_LAT};
    vecs[3]  = '{"divu_7_2",      3'd3, 32'h7,         32'h2, 32'h1,         32'h3,         DIV_LAT};
    vecs[4]  = '{"div_min_m1",    3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, DIV_LAT};
    vecs[5]  = '{"divu_5_0",      3'd3, 32'h5,         32'h0, 32'h5,         32'hFFFF_FFFF, EARLY_LAT};
    vecs[6]  = '{"reserved6",     3'd6, 32'h1,         32'h2, 32'h5,         32'hFFFF_FFFF, 0};
    vecs[7]  = '{"divu_3_10",     3'd3, 32'h3,         32'hA, 32'h3,         32'h0,         EARLY_LAT};
    vecs[8]  = '{"mthi",          3'd4, 32'hAAAA_5555, 32'h0, 32'hAAAA_5555, 32'h0,         0};
    vecs[9]  = '{"mult_max_max",  3'd0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h1, 2};
    vecs[10] = '{"div_m100_7",    3'd2, 32'hFFFF_FF9C, 32'h7, 32'hFFFF_FFFE, 32'hFFFF_FFF2, DIV_LAT};
    vecs[11] = '{"reserved7",     3'd7, 32'h9,         32'h9, 32'hFFFF_FFFE, 32'hFFFF_FFF2, 0};

    rst_n = 1'b0; req_valid = 1'b0; req_op = '0; req_src0 = '0; req_src1 = '0;
    flush = 1'b0; rd_sel = 1'b0;
    repeat (3) @(negedge clk);
    check("reset req_ready", 32'(req_ready), 32'd1);
    check("reset busy", 32'(busy), 32'd0);
    check("reset rd_valid", 32'(rd_valid), 32'd1);
    check("reset dbg_state", 32'(dbg_state), 32'd0);
    read_reg(1'b1, v); check("reset hi", v, 32'h0);
    read_reg(1'b0, v); check("reset lo", v, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Back-to-back MTHI/MTLO with req_ready held high.
    req_valid = 1'b1; req_op = 3'd4; req_src0 = 32'h1234_5678;
    @(negedge clk);
    check("mt ready after mthi", 32'(req_ready), 32'd1);
    read_reg(1'b1, v); check("mt hi", v, 32'h1234_5678);
    req_op = 3'd5; req_src0 = 32'h9ABC_DEF0;
    @(negedge clk);
    req_valid = 1'b0;
    check("mt ready after mtlo", 32'(req_ready), 32'd1);
    read_reg(1'b1, v); check("mt hi kept", v, 32'h1234_5678);
    read_reg(1'b0, v); check("mt lo", v, 32'h9ABC_DEF0);
    @(negedge clk);

    // Table of directed vectors.
    for (int i = 0; i < 12; i++)
      run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].lat);

    // Flush in the middle of a divide.
    run_op("pre_hi", 3'd4, 32'hA, 32'h0, 32'hA, 32'hFFFF_FFF2, 0);
    run_op("pre_lo", 3'd5, 32'hB, 32'h0, 32'hA, 32'hB, 0);
    req_valid = 1'b1; req_op = 3'd2; req_src0 = 32'd100; req_src1 = 32'd3;
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 2; i <= 10; i++) @(negedge clk);
    check("flush10 busy before", 32'(busy), 32'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush10 rd_valid", 32'(rd_valid), 32'd1);
    read_reg(1'b1, v); check("flush10 hi", v, 32'hA);
    read_reg(1'b0, v); check("flush10 lo", v, 32'hB);
    run_op("after_flush_divu", 3'd3, 32'd7, 32'd2, 32'd1, 32'd3, DIV_LAT);

    // Flush on the final divide cycle: no write.
    req_valid = 1'b1; req_op = 3'd2; req_src0 = 32'd100; req_src1 = 32'd3;
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 2; i <= DIV_LAT; i++) @(negedge clk);
    check("flushlast busy before", 32'(busy), 32'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flushlast rd_valid", 32'(rd_valid), 32'd1);
    read_reg(1'b1, v); check("flushlast hi", v, 32'd1);
    read_reg(1'b0, v); check("flushlast lo", v, 32'd3);

    // Flush in idle blocks an MTHI.
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'd4; req_src0 = 32'hDEAD_BEEF; flush = 1'b1;
    @(negedge clk);
    req_valid = 1'b0; flush = 1'b0;
    read_reg(1'b1, v); check("idle flush hi", v, 32'd1);
    @(negedge clk);

    // Randomised ops against the reference model.
    mhi = 32'd1;
    mlo = 32'd3;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: ra = $urandom;
        1: ra = $urandom_range(0, 20);
        2: ra = 32'h8000_0000;
        default: ra = 32'hFFFF_FFFF - $urandom_range(0, 20);
      endcase
      case ($urandom_range(0, 4))
        0: rb = $urandom;
        1: rb = $urandom_range(1, 20);
        2: rb = 32'h0;
        3: rb = 32'hFFFF_FFFF;
        default: rb = $urandom_range(0, 65535);
      endcase
      req_op = 3'($urandom_range(0, 7));
      ref_model(req_op, ra, rb, mhi, mlo, ehi, elo, elat);
      run_op($sformatf("rand%0d_op%0d", i, req_op), req_op, ra, rb, ehi, elo, elat);
      mhi = ehi;
      mlo = elo;
    end

    // Asynchronous reset in the middle of a divide.
    req_valid = 1'b1; req_op = 3'd3; req_src0 = 32'd1000; req_src1 = 32'd7;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("pre-reset busy", 32'(busy), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("async rst req_ready", 32'(req_ready), 32'd1);
    check("async rst busy", 32'(busy), 32'd0);
    check("async rst rd_valid", 32'(rd_valid), 32'd1);
    check("async rst dbg_state", 32'(dbg_state), 32'd0);
    read_reg(1'b1, v); check("async rst hi", v, 32'h0);
    read_reg(1'b0, v); check("async rst lo", v, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op("post_reset_mult", 3'd0, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
